modulus_counter_ctrl: RTL and testbench
=======================================

MODULUS_COUNTER_CTRL -- requirements
Module: modulus_counter_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 3, counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port cfg_valid, input, 1, configuration offer.
REQ-005 The block SHALL have port cfg_ready, output, 1, configuration accept; it is high only in IDLE.
REQ-006 The block SHALL have port cfg_mod, input, n, terminal value M; the count runs 0..M.
REQ-007 The block SHALL have port cfg_reps, input, 8, wrap count R; it exists only with MODCNT_REPEAT_EN.
REQ-008 The block SHALL have ports start and stop, input, 1 each, run control.
REQ-009 The block SHALL have port Q, output, n, current count.
REQ-010 The block SHALL have port tc, output, 1, terminal-count flag.
REQ-011 The block SHALL have port busy, output, 1, high when state != IDLE.
REQ-012 The block SHALL have port done, output, 1, one-cycle end-of-run pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 The block SHALL accept configuration when cfg_valid && cfg_ready, latching cfg_mod into mod_reg (and cfg_reps into reps_reg) at that edge.
REQ-015 While busy, cfg_ready SHALL be 0, and cfg_valid SHALL be ignored with mod_reg unchanged.
REQ-016 In IDLE, start=1 with stop=0 SHALL move to RUN at the next edge with Q=0; if start and stop are both high in IDLE, the block SHALL stay in IDLE.
REQ-017 A configuration and start in the same IDLE cycle SHALL both take effect, and the run SHALL use the new mod_reg.
REQ-018 In RUN, Q SHALL advance by 1 each cycle, and when Q==mod_reg the next Q SHALL be 0 (wrap).
REQ-019 tc SHALL equal (state==RUN && Q==mod_reg), decoded from registers with no extra latency.
REQ-020 When mod_reg==0, Q SHALL hold 0 and tc SHALL be 1 on every RUN cycle.
REQ-021 Increments SHALL be modulo 2^n, and mod_reg==2^n-1 SHALL give natural wrap-around.
REQ-022 start during RUN SHALL be ignored.
REQ-023 stop during RUN SHALL move to IDLE at the next edge with Q=0, and stop SHALL take priority over a coincident tc or end-of-run.
REQ-024 Q SHALL be 0 in IDLE and DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1, then go to IDLE.

Reset
REQ-026 When reset_n=0, the block SHALL immediately (asynchronously) set: state=IDLE, Q=0, mod_reg=5, reps_reg=0, wrap counter=0, tc=0, done=0, busy=0, cfg_ready=1.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-028 After reset_n deasserts, the first start SHALL use mod_reg=5.

Configuration
REQ-029 Macro MODCNT_REPEAT_EN SHALL gate the repeat feature.
REQ-030 With MODCNT_REPEAT_EN defined:
- cfg_reps is present.
- R==0 means run continuously.
- R>0 means after the R-th tc the FSM goes RUN->DONE, with done=1 in the following cycle.
REQ-031 With MODCNT_REPEAT_EN undefined:
- cfg_reps, reps_reg and the wrap counter are absent.
- RUN continues until stop.
- DONE is unreachable, and done is tied to 0.

Structure
REQ-032 Package modcnt_pkg SHALL hold the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the constant MODCNT_DEFAULT_MOD=5 and the constant REPS_W=8.
REQ-033 Sub-module mod_counter_prog SHALL hold the counter: inputs clk, reset_n, en, clr, mod[n-1:0]; outputs Q[n-1:0], wrap.
REQ-034 The controller SHALL own the FSM, the cfg handshake and the repeat counter.

Verification
REQ-035 Scenario, n=3, no macro: cfg_mod=5, start -> Q 0,1,2,3,4,5,0,1...; tc=1 only when Q=5; busy=1.
REQ-036 Scenario: cfg_mod=0, start -> Q stays 0; tc=1 every RUN cycle.
REQ-037 Scenario: run with M=5, stop pulsed at Q=3 -> next cycle Q=0, busy=0, cfg_ready=1, done=0.
REQ-038 Scenario, MODCNT_REPEAT_EN: cfg_mod=2, cfg_reps=2, start -> Q 0,1,2,0,1,2; tc twice; then DONE with done=1 for one cycle; then IDLE.
REQ-039 Scenario: reset_n low while Q=4 -> Q=0 and busy=0 without waiting for a clock edge; after release, start -> counts to 5 (default mod).
REQ-040 Scenario: cfg_valid with cfg_mod=2 during RUN with M=5 -> cfg_ready=0, wrap still at 5; retried in IDLE -> accepted, next run wraps at 2.

Source files
------------

// File: rtl/modcnt_pkg.sv
// Shared types and constants for the programmable modulus counter.
package modcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MODCNT_DEFAULT_MOD = 5;
  localparam int REPS_W             = 8;

endpackage

// File: rtl/mod_counter_prog.sv
// Programmable modulus counter: counts 0..mod, wraps to 0; wrap flags Q==mod.
module mod_counter_prog #(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [n-1:0] mod,
  output logic [n-1:0] Q,
  output logic         wrap
);

  assign wrap = (Q == mod);

  // clr wins over en so the controller can park the count at 0 in any state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else if (clr) begin
      Q <= '0;
    end else if (en) begin
      Q <= wrap ? '0 : Q + n'(1);
    end
  end

endmodule

// File: rtl/modulus_counter_ctrl.sv
// Run controller for mod_counter_prog: cfg handshake, IDLE/RUN/DONE FSM, optional
// repeat limit enabled by the MODCNT_REPEAT_EN macro.
module modulus_counter_ctrl
  import modcnt_pkg::*;
#(
  parameter int n = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [n-1:0]      cfg_mod,
`ifdef MODCNT_REPEAT_EN
  input  logic [REPS_W-1:0] cfg_reps,
`endif
  input  logic              start,
  input  logic              stop,
  output logic [n-1:0]      Q,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  state_t       state, state_nxt;
  logic [n-1:0] mod_reg;
  logic         cnt_en, cnt_clr, at_mod, cfg_fire, last_wrap;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign tc        = (state == RUN) && at_mod;

`ifdef MODCNT_REPEAT_EN
  logic [REPS_W-1:0] reps_reg, wrap_cnt;

  // R==0 never matches, so the run continues until stop
  assign last_wrap = tc && (reps_reg != '0) && (wrap_cnt == reps_reg - REPS_W'(1));
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reps_reg <= '0;
      wrap_cnt <= '0;
    end else begin
      if (cfg_fire) reps_reg <= cfg_reps;
      if (state != RUN) wrap_cnt <= '0;
      else if (tc)      wrap_cnt <= wrap_cnt + REPS_W'(1);
    end
  end
`else
  assign last_wrap = 1'b0;
  assign done      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mod_reg <= n'(MODCNT_DEFAULT_MOD);
    end else begin
      state <= state_nxt;
      if (cfg_fire) mod_reg <= cfg_mod;
    end
  end

  // Counter is held clear everywhere except a RUN cycle that stays in RUN
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b1;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (last_wrap) begin
          state_nxt = DONE;
        end else begin
          cnt_en  = 1'b1;
          cnt_clr = 1'b0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mod_counter_prog #(.n(n)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .mod     (mod_reg),
    .Q       (Q),
    .wrap    (at_mod)
  );

endmodule

// File: tb/tb_modulus_counter_ctrl.sv
// Scoreboard bench for modulus_counter_ctrl (n=3): driver queues expected outputs per cycle.
module tb_modulus_counter_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [N-1:0] cfg_mod = '0;
  logic [7:0]   cfg_reps = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] Q;
  logic         tc, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [6:0] exp;
    string      name;
  } sb_t;
  sb_t sb[$];

  modulus_counter_ctrl #(.n(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mod   (cfg_mod),
`ifdef MODCNT_REPEAT_EN
    .cfg_reps  (cfg_reps),
`endif
    .start     (start),
    .stop      (stop),
    .Q         (Q),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] obs();
    return {Q, tc, busy, cfg_ready, done};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got Q=%0d tc=%b busy=%b rdy=%b done=%b, want Q=%0d tc=%b busy=%b rdy=%b done=%b",
               name, cyc, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the entry scheduled for the current cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stale_%s: entry for cyc %0d unchecked at cyc %0d", sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      sb_t e;
      e = sb.pop_front();
      check(e.name, obs(), e.exp);
    end
  end

  // One cycle: drive inputs at negedge, queue outputs expected after the next posedge
  task automatic step(input string name, input logic st, input logic sp, input logic cv,
                      input logic [N-1:0] cm, input logic [N-1:0] eq, input logic etc,
                      input logic eb, input logic ed);
    sb_t e;
    @(negedge clk);
    start = st; stop = sp; cfg_valid = cv; cfg_mod = cm;
    e.cyc  = cyc + 1;
    e.exp  = {eq, etc, eb, ~eb, ed};
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    // Async reset values, before any clock edge
    #2;
    check("reset_vals", obs(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;

    // Start with default modulus, run to Q=4, then async reset mid-run
    step("start_def", 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step("count_def", 0, 0, 0, 0, N'(i), 0, 1, 0);
    @(negedge clk);
    idle_in();
    #2 reset_n = 1'b0;
    #1 check("async_reset", obs(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // After reset the run uses modulus 5: 0..5 then wrap
    step("start_rst", 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step("count5", 0, 0, 0, 0, N'(i), (i == 5), 1, 0);
    step("wrap5", 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) step("count5b", 0, 0, 0, 0, N'(i), 0, 1, 0);
    step("stop_at3", 0, 1, 0, 0, 0, 0, 0, 0);

    // Config during RUN is ignored; retried in IDLE it is accepted
    step("start_m5", 1, 0, 0, 0, 0, 0, 1, 0);
    step("cfg_busy", 0, 0, 1, 2, 1, 0, 1, 0);
    step("cfg_busy2", 1, 0, 1, 2, 2, 0, 1, 0);
    for (int i = 3; i <= 5; i++) step("still_m5", 0, 0, 0, 0, N'(i), (i == 5), 1, 0);
    step("wrap_m5", 0, 0, 0, 0, 0, 0, 1, 0);
    step("stop_m5", 0, 1, 0, 0, 0, 0, 0, 0);
    step("cfg_idle", 0, 0, 1, 2, 0, 0, 0, 0);
    step("start_m2", 1, 0, 0, 0, 0, 0, 1, 0);
    step("m2_q1", 0, 0, 0, 0, 1, 0, 1, 0);
    step("m2_q2", 0, 0, 0, 0, 2, 1, 1, 0);
    step("m2_wrap", 0, 0, 0, 0, 0, 0, 1, 0);
    step("m2_q1b", 0, 0, 0, 0, 1, 0, 1, 0);
    step("stop_m2", 0, 1, 0, 0, 0, 0, 0, 0);

    // Config and start together, modulus 0: Q holds 0, tc every RUN cycle; start in RUN ignored
    step("cfg_start_m0", 1, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("m0_hold", 0, 0, 0, 0, 0, 1, 1, 0);
    step("m0_start_run", 1, 0, 0, 0, 0, 1, 1, 0);
    step("stop_m0", 0, 1, 0, 0, 0, 0, 0, 0);

    // start with stop in IDLE stays idle
    step("start_stop", 1, 1, 0, 0, 0, 0, 0, 0);

    // Modulus 2^n-1: natural wrap, then stop coinciding with tc
    step("cfg_start_m7", 1, 0, 1, 7, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) step("m7_up", 0, 0, 0, 0, N'(i), (i == 7), 1, 0);
    step("m7_wrap", 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) step("m7_up2", 0, 0, 0, 0, N'(i), (i == 7), 1, 0);
    step("stop_on_tc", 0, 1, 0, 0, 0, 0, 0, 0);
    step("idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MODCNT_REPEAT_EN
    // Two wraps of modulus 2, then a single DONE cycle
    @(negedge clk);
    cfg_reps = 8'd2;
    step("rep_start", 1, 0, 1, 2, 0, 0, 1, 0);
    step("rep_q1", 0, 0, 0, 0, 1, 0, 1, 0);
    step("rep_q2", 0, 0, 0, 0, 2, 1, 1, 0);
    step("rep_q0", 0, 0, 0, 0, 0, 0, 1, 0);
    step("rep_q1b", 0, 0, 0, 0, 1, 0, 1, 0);
    step("rep_q2b", 0, 0, 0, 0, 2, 1, 1, 0);
    step("rep_done", 0, 0, 0, 0, 0, 0, 1, 1);
    step("rep_idle", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    @(negedge clk);
    idle_in();
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
